// File: rtl/wishbone_1mst_to_nslv.sv
// Wishbone classic 1-master to NB_SLV-slave router with a base/mask decode table.
// Registers the routing decision and response; terminates unmapped or hung accesses with an error.
module wishbone_1mst_to_nslv #(
  parameter int unsigned          NB_SLV    = 4,
  parameter logic [NB_SLV*32-1:0] BASE_ADDR = {32'h30030000, 32'h30020000,
                                               32'h30010000, 32'h30000000},
  parameter logic [NB_SLV*32-1:0] MASK_ADDR = {NB_SLV{32'hFFFF0000}},
  parameter int unsigned          TO_WIDTH  = 8,
  parameter int unsigned          TIMEOUT   = 255,
  parameter logic [31:0]          ERR_DATA  = 32'hDEADBEEF
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   wbs_m_cyc_i,
  input  logic                   wbs_m_stb_i,
  input  logic                   wbs_m_we_i,
  input  logic [31:0]            wbs_m_adr_i,
  input  logic [31:0]            wbs_m_dat_i,
  input  logic [3:0]             wbs_m_sel_i,
  output logic [31:0]            wbs_m_dat_o,
  output logic                   wbs_m_ack_o,
  output logic                   wbs_m_err_o,
  output logic [NB_SLV-1:0]      wbs_s_cyc_o,
  output logic [NB_SLV-1:0]      wbs_s_stb_o,
  output logic [NB_SLV-1:0]      wbs_s_we_o,
  output logic [NB_SLV*32-1:0]   wbs_s_adr_o,
  output logic [NB_SLV*32-1:0]   wbs_s_dat_o,
  output logic [NB_SLV*4-1:0]    wbs_s_sel_o,
  input  logic [NB_SLV*32-1:0]   wbs_s_dat_i,
  input  logic [NB_SLV-1:0]      wbs_s_ack_i,
  output logic                   err_irq,
  output logic [7:0]             err_count
);

  typedef enum logic [1:0] {StIdle, StActive, StDone, StErr} state_e;

  state_e              state_q, state_d;
  logic [NB_SLV-1:0]   slv_q, slv_d, hit;
  logic [31:0]         adr_q, adr_d, wdat_q, wdat_d, rdat_q, rdat_d;
  logic [3:0]          bsel_q, bsel_d;
  logic                we_q, we_d;
  logic [TO_WIDTH-1:0] timer_q, timer_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                found, slv_ack;
  logic [31:0]         slv_rdat;

  // Priority decode: the lowest matching index wins.
  always_comb begin
    hit   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NB_SLV; i++) begin
      if (!found && ((wbs_m_adr_i & MASK_ADDR[32*i +: 32]) ==
                     (BASE_ADDR[32*i +: 32] & MASK_ADDR[32*i +: 32]))) begin
        hit[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    slv_rdat = '0;
    for (int unsigned i = 0; i < NB_SLV; i++) begin
      if (slv_q[i]) slv_rdat = slv_rdat | wbs_s_dat_i[32*i +: 32];
    end
    slv_ack = |(wbs_s_ack_i & slv_q);
  end

  always_comb begin
    state_d = state_q;
    slv_d   = slv_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    bsel_d  = bsel_q;
    we_d    = we_q;
    rdat_d  = rdat_q;
    cnt_d   = cnt_q;
    timer_d = '0;
    unique case (state_q)
      StIdle: begin
        if (wbs_m_cyc_i && wbs_m_stb_i) begin
          slv_d   = hit;
          adr_d   = wbs_m_adr_i;
          wdat_d  = wbs_m_dat_i;
          bsel_d  = wbs_m_sel_i;
          we_d    = wbs_m_we_i;
          state_d = StActive;
        end
      end
      StActive: begin
        if (!wbs_m_cyc_i) begin
          state_d = StIdle;
        end else if (slv_q == '0) begin
          // Unmapped: one cycle with no slave selected, so the error ack lands two cycles out.
          state_d = StErr;
          rdat_d  = ERR_DATA;
          cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        end else if (slv_ack) begin
          state_d = StDone;
          rdat_d  = slv_rdat;
        end else if (timer_q == TO_WIDTH'(TIMEOUT - 1)) begin
          state_d = StErr;
          rdat_d  = ERR_DATA;
          cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= StIdle;
      slv_q   <= '0;
      adr_q   <= '0;
      wdat_q  <= '0;
      bsel_q  <= '0;
      we_q    <= 1'b0;
      rdat_q  <= '0;
      cnt_q   <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      slv_q   <= slv_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      bsel_q  <= bsel_d;
      we_q    <= we_d;
      rdat_q  <= rdat_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    wbs_s_cyc_o = '0;
    wbs_s_stb_o = '0;
    wbs_s_we_o  = '0;
    wbs_s_adr_o = '0;
    wbs_s_dat_o = '0;
    wbs_s_sel_o = '0;
    for (int unsigned i = 0; i < NB_SLV; i++) begin
      if (state_q == StActive && slv_q[i]) begin
        wbs_s_cyc_o[i]          = 1'b1;
        wbs_s_stb_o[i]          = 1'b1;
        wbs_s_we_o[i]           = we_q;
        wbs_s_adr_o[32*i +: 32] = adr_q;
        wbs_s_dat_o[32*i +: 32] = wdat_q;
        wbs_s_sel_o[4*i +: 4]   = bsel_q;
      end
    end
  end

  assign wbs_m_ack_o = (state_q == StDone) || (state_q == StErr);
  assign wbs_m_err_o = (state_q == StErr);
  assign err_irq     = (state_q == StErr);
  assign wbs_m_dat_o = rdat_q;
  assign err_count   = cnt_q;

endmodule
